// File: rtl/siggen_pkg.sv
// Shared defaults for the sine generator. The address-generator top level and the
// dual-port sine ROM instantiation use these defaults so that they agree on the address width.
package siggen_pkg;

  // ROM address width (A).
  localparam int unsigned SIGGEN_ADDRESS_WIDTH = 8;

  // Fractional bits of the phase accumulator (F).
  localparam int unsigned SIGGEN_FRAC_WIDTH    = 4;

  // Accumulator width, A.F fixed point.
  localparam int unsigned SIGGEN_ACC_WIDTH     = SIGGEN_ADDRESS_WIDTH + SIGGEN_FRAC_WIDTH;

  // Reset tuning word: 1 << F advances one ROM address per enabled clock.
  localparam int unsigned SIGGEN_DEFAULT_INCR  = 1 << SIGGEN_FRAC_WIDTH;

endpackage : siggen_pkg

// File: rtl/sine_cfg_shadow.sv
// Configuration shadow for the sine address generator.
// A tuning word and phase offset are accepted over a valid/ready handshake into shadow
// registers. They are promoted to the active registers only when the top level reports
// a phase wrap, or when the accumulator is idle. As a result, frequency and phase never
// change in the middle of a period.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   cfg_valid       new configuration presented
//   cfg_ready       combinational, high while no configuration is pending
//   cfg_incr        tuning word (A.F)
//   cfg_offset      channel-2 phase offset in ROM addresses
//   en, phase_clr   accumulator controls from the top level
//   carry           accumulator overflow of this cycle's addition (combinational)
//   apply_c         combinational: the pending configuration is promoted on this edge
//   incr_active     tuning word in use
//   offset_active   phase offset in use
//   shadow_offset   captured offset; the top level uses it for addr2 on the apply edge
module sine_cfg_shadow
  import siggen_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = SIGGEN_ADDRESS_WIDTH,
  parameter int unsigned FRAC_WIDTH    = SIGGEN_FRAC_WIDTH,
  parameter int unsigned DEFAULT_INCR  = SIGGEN_DEFAULT_INCR
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] cfg_incr,
  input  logic [ADDRESS_WIDTH-1:0]            cfg_offset,
  input  logic                                en,
  input  logic                                phase_clr,
  input  logic                                carry,
  output logic                                apply_c,
  output logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] incr_active,
  output logic [ADDRESS_WIDTH-1:0]            offset_active,
  output logic [ADDRESS_WIDTH-1:0]            shadow_offset
);

  localparam int unsigned ACC_W = ADDRESS_WIDTH + FRAC_WIDTH;

  logic                     pending_q,       pending_d;
  logic [ACC_W-1:0]         shadow_incr_q,   shadow_incr_d;
  logic [ADDRESS_WIDTH-1:0] shadow_offset_q, shadow_offset_d;
  logic [ACC_W-1:0]         incr_active_q,   incr_active_d;
  logic [ADDRESS_WIDTH-1:0] offset_active_q, offset_active_d;
  logic                     accept_c;

  // A single configuration slot: accept only when the slot is empty.
  assign cfg_ready = !pending_q;
  assign accept_c  = cfg_valid && !pending_q;

  // Promote at a phase wrap while running, or at any cycle while the accumulator is idle.
  // A phase clear blocks promotion.
  assign apply_c = pending_q && !phase_clr && (!en || carry);

  // Next-state logic for the pending flag, the shadow registers and the active registers.
  // Acceptance and apply are mutually exclusive because both depend on pending_q.
  always_comb begin
    pending_d       = pending_q;
    shadow_incr_d   = shadow_incr_q;
    shadow_offset_d = shadow_offset_q;
    incr_active_d   = incr_active_q;
    offset_active_d = offset_active_q;
    if (accept_c) begin
      pending_d       = 1'b1;
      shadow_incr_d   = cfg_incr;
      shadow_offset_d = cfg_offset;
    end else if (apply_c) begin
      pending_d       = 1'b0;
      incr_active_d   = shadow_incr_q;
      offset_active_d = shadow_offset_q;
    end
  end

  // Configuration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q       <= 1'b0;
      shadow_incr_q   <= '0;
      shadow_offset_q <= '0;
      incr_active_q   <= ACC_W'(DEFAULT_INCR);
      offset_active_q <= '0;
    end else begin
      pending_q       <= pending_d;
      shadow_incr_q   <= shadow_incr_d;
      shadow_offset_q <= shadow_offset_d;
      incr_active_q   <= incr_active_d;
      offset_active_q <= offset_active_d;
    end
  end

  assign incr_active   = incr_active_q;
  assign offset_active = offset_active_q;
  assign shadow_offset = shadow_offset_q;

endmodule : sine_cfg_shadow

// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator for the dual-port sine ROM.
// A fractional tuning word sets the output frequency. addr2 leads addr1 by a programmable
// offset. Configuration changes take effect only at a phase wrap, or while the
// accumulator is idle.
//
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   en           advance the accumulator this cycle
//   phase_clr    synchronous accumulator clear; takes priority over en
//   cfg_valid    new configuration presented
//   cfg_ready    combinational, high while no configuration is pending
//   cfg_incr     tuning word, unsigned A.F
//   cfg_offset   addr2 phase offset in ROM addresses
//   addr1/addr2  registered ROM addresses for channels 1 and 2
//   wrap         registered one-cycle pulse when the accumulator overflowed on this update
module sine_addr_gen
  import siggen_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = SIGGEN_ADDRESS_WIDTH,
  parameter int unsigned FRAC_WIDTH    = SIGGEN_FRAC_WIDTH,
  parameter int unsigned DEFAULT_INCR  = SIGGEN_DEFAULT_INCR
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                phase_clr,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] cfg_incr,
  input  logic [ADDRESS_WIDTH-1:0]            cfg_offset,
  output logic [ADDRESS_WIDTH-1:0]            addr1,
  output logic [ADDRESS_WIDTH-1:0]            addr2,
  output logic                                wrap
);

  localparam int unsigned ACC_W = ADDRESS_WIDTH + FRAC_WIDTH;

  logic [ACC_W-1:0]         acc_q,   acc_d;
  logic [ADDRESS_WIDTH-1:0] addr1_q, addr1_d;
  logic [ADDRESS_WIDTH-1:0] addr2_q, addr2_d;
  logic                     wrap_q,  wrap_d;

  logic [ACC_W:0]           sum_c;
  logic                     carry_c;
  logic [ACC_W-1:0]         acc_n_c;
  logic [ADDRESS_WIDTH-1:0] addr_n_c;
  logic [ADDRESS_WIDTH-1:0] off_c;

  logic                     apply_c;
  logic [ACC_W-1:0]         incr_active;
  logic [ADDRESS_WIDTH-1:0] offset_active;
  logic [ADDRESS_WIDTH-1:0] shadow_offset;

  // Handshake, shadow/active configuration and apply decision.
  sine_cfg_shadow #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .FRAC_WIDTH    (FRAC_WIDTH),
    .DEFAULT_INCR  (DEFAULT_INCR)
  ) u_cfg_shadow (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_incr      (cfg_incr),
    .cfg_offset    (cfg_offset),
    .en            (en),
    .phase_clr     (phase_clr),
    .carry         (carry_c),
    .apply_c       (apply_c),
    .incr_active   (incr_active),
    .offset_active (offset_active),
    .shadow_offset (shadow_offset)
  );

  // Accumulator sum with one extra bit, so that an exact landing on 0 still reports a carry.
  // These assignments are kept outside the register-update block because carry feeds the apply
  // decision and the apply decision feeds back into the offset selection.
  assign sum_c    = {1'b0, acc_q} + {1'b0, incr_active};
  assign carry_c  = sum_c[ACC_W];
  assign acc_n_c  = sum_c[ACC_W-1:0];
  assign addr_n_c = acc_n_c[ACC_W-1:FRAC_WIDTH];

  // On the apply edge the new offset already drives addr2.
  assign off_c = apply_c ? shadow_offset : offset_active;

  // Next-state logic for the accumulator and the address registers.
  always_comb begin
    acc_d   = acc_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    wrap_d  = 1'b0;
    if (phase_clr) begin
      acc_d   = '0;
      addr1_d = '0;
      addr2_d = offset_active;
    end else if (en) begin
      acc_d   = acc_n_c;
      wrap_d  = carry_c;
      addr1_d = addr_n_c;
      addr2_d = addr_n_c + off_c;
    end else if (apply_c) begin
      // While idle, an applied offset re-aligns addr2 to the held addr1.
      addr2_d = addr1_q + shadow_offset;
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      wrap_q  <= wrap_d;
    end
  end

  assign addr1 = addr1_q;
  assign addr2 = addr2_q;
  assign wrap  = wrap_q;

endmodule : sine_addr_gen
